rect_palette_ctrl: RTL and testbench
====================================

RECT_PALETTE_CTRL -- requirements
Module: rect_palette_ctrl

Interface
REQ-001 SHALL have parameter NUM_RECT, default 8, number of rectangle table entries (power of 2, 2..16).
REQ-002 SHALL have parameter IDX_W, default 4, palette index width.
REQ-003 SHALL have port pixclk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port x, input, 12, current pixel column.
REQ-006 SHALL have port y, input, 12, current pixel row.
REQ-007 SHALL have port draw_area, input, 1, pixel is in the visible region.
REQ-008 SHALL have port animate, input, 1, one-cycle pulse at end of the visible frame.
REQ-009 SHALL have port blink_frames, input, 8, frames per blink half-period; 0 disables blinking.
REQ-010 SHALL have port cfg_valid, input, 1, config write request.
REQ-011 SHALL have port cfg_ready, output, 1, config write accepted when valid&&ready.
REQ-012 SHALL have port cfg_sel, input, log2(NUM_RECT), target entry.
REQ-013 SHALL have port cfg_field, input, 3, field: 0=x0, 1=x1, 2=y0, 3=y1, 4=color_on, 5=color_off, 6=enable, 7=ignored.
REQ-014 SHALL have port cfg_data, input, 12, field value; colors use [IDX_W-1:0], enable uses [0].
REQ-015 SHALL have port pix_idx, output, IDX_W, palette index for the downstream color lookup.
REQ-016 SHALL have port commit_busy, output, 1, shadow-to-active copy in progress.

Function
REQ-017 SHALL hold two tables: shadow (written by cfg) and active (used for drawing); each entry holds x0, x1, y0, y1, color_on, color_off, enable.
REQ-018 SHALL write cfg_data into shadow[cfg_sel].cfg_field on each cycle with cfg_valid&&cfg_ready, and set a dirty flag.
REQ-019 SHALL use FSM states IDLE and COPY; cfg_ready=1 only in IDLE.
REQ-020 SHALL go IDLE->COPY on animate when dirty=1 or a write is accepted in the same cycle; that write SHALL be included in the copy.
REQ-021 SHALL, in COPY, copy one entry per cycle (index 0..NUM_RECT-1), return to IDLE after the last entry, clear dirty, and assert commit_busy throughout COPY.
REQ-022 SHALL ignore animate while in COPY; animate with dirty=0 SHALL leave the FSM in IDLE.
REQ-023 SHALL treat entry i as a hit when enable=1, x0<=x<=x1 and y0<=y<=y1, with unsigned 12-bit compares; x0>x1 or y0>y1 never hits.
REQ-024 SHALL register pix_idx with 2-cycle latency from x/y/draw_area: stage 1 registers the per-entry hit vector and draw_area; stage 2 priority-encodes it.
REQ-025 SHALL give priority to the lowest-index hit entry; no hit or draw_area=0 SHALL yield pix_idx=0.
REQ-026 SHALL output the winner's color_on when blink_phase=1 and color_off when blink_phase=0.
REQ-027 SHALL advance a frame counter on each animate; when blink_frames!=0 and the counter equals blink_frames-1, it SHALL wrap to 0 and toggle blink_phase.
REQ-028 SHALL hold blink_phase=1 and the frame counter at 0 while blink_frames=0.
REQ-029 SHALL let the pixel pipeline read active entries mid-copy; a mixed old/new frame is permitted only if animate is not in blanking.

Reset
REQ-030 SHALL, on rst, immediately set FSM=IDLE, dirty=0, copy index=0, frame counter=0, blink_phase=1, pipeline registers=0, pix_idx=0, commit_busy=0, cfg_ready=1 (after deassertion).
REQ-031 SHALL clear every field of every shadow and active entry to 0 on rst, so all entries are disabled.
REQ-032 SHALL, on rst asserted mid-COPY, abandon the copy; no partial state survives.

Verification
REQ-033 Reset, then sweep a frame -> pix_idx=0 everywhere; cfg_ready=1; commit_busy=0.
REQ-034 Write entry 0 = {508,526,316,385,on=3,off=4,en=1}, pulse animate -> commit_busy high 8 cycles; next frame, pix_idx=3 two cycles after (x,y)=(508,316) and 0 at (527,316).
REQ-035 Overlap: entry 1 = {494,520,300,400,on=5,en=1} plus entry 0 as in REQ-034 -> pix_idx=3 at (510,320) and 5 at (495,320).
REQ-036 blink_frames=2 -> pix_idx alternates 3,3,4,4,3 over successive frames at (510,320); blink_frames=0 -> constant 3.
REQ-037 Write accepted in the same cycle as animate -> that value is visible next frame; cfg_valid during COPY -> cfg_ready=0, no write until IDLE.
REQ-038 rst pulse at COPY cycle 3 -> commit_busy=0 at once; active table all-disabled; pix_idx=0.

Source files
------------

// File: rtl/rect_palette_ctrl.sv
// Rectangle overlay palette-index generator with double-buffered rectangle table.
// Config writes land in a shadow table; animate copies shadow to active one entry per cycle.
module rect_palette_ctrl #(
  parameter int unsigned NUM_RECT = 8,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                        pixclk,
  input  logic                        rst,
  input  logic [11:0]                 x,
  input  logic [11:0]                 y,
  input  logic                        draw_area,
  input  logic                        animate,
  input  logic [7:0]                  blink_frames,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [$clog2(NUM_RECT)-1:0] cfg_sel,
  input  logic [2:0]                  cfg_field,
  input  logic [11:0]                 cfg_data,
  output logic [IDX_W-1:0]            pix_idx,
  output logic                        commit_busy
);

  localparam int unsigned SEL_W = $clog2(NUM_RECT);

  typedef struct packed {
    logic [11:0]      x0;
    logic [11:0]      x1;
    logic [11:0]      y0;
    logic [11:0]      y1;
    logic [IDX_W-1:0] color_on;
    logic [IDX_W-1:0] color_off;
    logic             enable;
  } rect_t;

  typedef enum logic {IDLE, COPY} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     copy_idx_q, copy_idx_d;
  logic                 dirty_q, dirty_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 commit_busy_q, commit_busy_d;
  rect_t                shadow_q [NUM_RECT];
  rect_t                shadow_d [NUM_RECT];
  rect_t                active_q [NUM_RECT];
  rect_t                active_d [NUM_RECT];
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic [NUM_RECT-1:0]  hit_q, hit_d;
  logic                 da_q, da_d;
  logic [IDX_W-1:0]     pix_idx_q, pix_idx_d;
  logic                 wr_fire;
  logic                 found;

  assign wr_fire = cfg_valid && cfg_ready_q;

  // Config write path and shadow-to-active commit FSM
  always_comb begin
    state_d    = state_q;
    copy_idx_d = copy_idx_q;
    dirty_d    = dirty_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    if (wr_fire) begin
      dirty_d = 1'b1;
      case (cfg_field)
        3'd0:    shadow_d[cfg_sel].x0        = cfg_data;
        3'd1:    shadow_d[cfg_sel].x1        = cfg_data;
        3'd2:    shadow_d[cfg_sel].y0        = cfg_data;
        3'd3:    shadow_d[cfg_sel].y1        = cfg_data;
        3'd4:    shadow_d[cfg_sel].color_on  = cfg_data[IDX_W-1:0];
        3'd5:    shadow_d[cfg_sel].color_off = cfg_data[IDX_W-1:0];
        3'd6:    shadow_d[cfg_sel].enable    = cfg_data[0];
        default: ;
      endcase
    end
    case (state_q)
      IDLE: begin
        if (animate && (dirty_q || wr_fire)) begin
          state_d    = COPY;
          copy_idx_d = '0;
        end
      end
      COPY: begin
        active_d[copy_idx_q] = shadow_q[copy_idx_q];
        if (copy_idx_q == SEL_W'(NUM_RECT - 1)) begin
          state_d    = IDLE;
          dirty_d    = 1'b0;
          copy_idx_d = '0;
        end else begin
          copy_idx_d = copy_idx_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    cfg_ready_d   = (state_d == IDLE);
    commit_busy_d = (state_d == COPY);
  end

  // Blink phase: forced on while blinking is disabled
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (blink_frames == 8'd0) begin
      frame_cnt_d   = 8'd0;
      blink_phase_d = 1'b1;
    end else if (animate) begin
      if (frame_cnt_q == blink_frames - 8'd1) begin
        frame_cnt_d   = 8'd0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Pixel pipeline: stage 1 hit vector, stage 2 lowest-index priority pick
  always_comb begin
    da_d      = draw_area;
    hit_d     = '0;
    pix_idx_d = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_RECT; i++) begin
      hit_d[i] = active_q[i].enable &&
                 (x >= active_q[i].x0) && (x <= active_q[i].x1) &&
                 (y >= active_q[i].y0) && (y <= active_q[i].y1);
    end
    if (da_q) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        if (!found && hit_q[i]) begin
          found     = 1'b1;
          pix_idx_d = blink_phase_q ? active_q[i].color_on : active_q[i].color_off;
        end
      end
    end
  end

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      copy_idx_q    <= '0;
      dirty_q       <= 1'b0;
      cfg_ready_q   <= 1'b1;
      commit_busy_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b1;
      hit_q         <= '0;
      da_q          <= 1'b0;
      pix_idx_q     <= '0;
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      copy_idx_q    <= copy_idx_d;
      dirty_q       <= dirty_d;
      cfg_ready_q   <= cfg_ready_d;
      commit_busy_q <= commit_busy_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      hit_q         <= hit_d;
      da_q          <= da_d;
      pix_idx_q     <= pix_idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign commit_busy = commit_busy_q;
  assign pix_idx     = pix_idx_q;

endmodule

// File: tb/tb_rect_palette_ctrl.sv
// Directed bench for rect_palette_ctrl: commit timing, hit/priority, blink and reset behaviour.
module tb_rect_palette_ctrl;

  localparam int unsigned NUM_RECT = 8;
  localparam int unsigned IDX_W    = 4;

  logic             pixclk;
  logic             rst;
  logic [11:0]      x;
  logic [11:0]      y;
  logic             draw_area;
  logic             animate;
  logic [7:0]       blink_frames;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_sel;
  logic [2:0]       cfg_field;
  logic [11:0]      cfg_data;
  logic [IDX_W-1:0] pix_idx;
  logic             commit_busy;

  int total = 0;
  int bad   = 0;

  rect_palette_ctrl #(.NUM_RECT(NUM_RECT), .IDX_W(IDX_W)) dut (
    .pixclk(pixclk), .rst(rst), .x(x), .y(y), .draw_area(draw_area),
    .animate(animate), .blink_frames(blink_frames), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_field(cfg_field),
    .cfg_data(cfg_data), .pix_idx(pix_idx), .commit_busy(commit_busy)
  );

  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  task automatic cfg_wr(input int sel, input int fld, input int data);
    cfg_valid = 1'b1;
    cfg_sel   = 3'(sel);
    cfg_field = 3'(fld);
    cfg_data  = 12'(data);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wr_rect(input int sel, input int x0, input int x1, input int y0,
                         input int y1, input int con, input int coff, input int en);
    cfg_wr(sel, 0, x0);
    cfg_wr(sel, 1, x1);
    cfg_wr(sel, 2, y0);
    cfg_wr(sel, 3, y1);
    cfg_wr(sel, 4, con);
    cfg_wr(sel, 5, coff);
    cfg_wr(sel, 6, en);
  endtask

  task automatic pulse_anim();
    animate = 1'b1;
    tick();
    animate = 1'b0;
  endtask

  task automatic wait_copy(output int n);
    n = 0;
    while (commit_busy === 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic pix(input int px, input int py, input logic da, output logic [IDX_W-1:0] o);
    x         = 12'(px);
    y         = 12'(py);
    draw_area = da;
    tick();
    tick();
    o         = pix_idx;
    draw_area = 1'b0;
  endtask

  initial begin
    logic [IDX_W-1:0] v;
    int n;
    int exp_blink [4];
    exp_blink[0] = 3; exp_blink[1] = 4; exp_blink[2] = 4; exp_blink[3] = 3;

    rst = 1'b1; x = '0; y = '0; draw_area = 1'b0; animate = 1'b0;
    blink_frames = 8'd0; cfg_valid = 1'b0; cfg_sel = '0; cfg_field = '0; cfg_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state and an empty-table sweep
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(commit_busy), 0);
    chk("rst_pix", 32'(pix_idx), 0);
    for (int i = 0; i < 4; i++) begin
      pix(100 + i * 300, 50 + i * 200, 1'b1, v);
      chk("rst_sweep", 32'(v), 0);
    end

    // Single rectangle, commit length and edges
    wr_rect(0, 508, 526, 316, 385, 3, 4, 1);
    pulse_anim();
    chk("copy_busy_start", 32'(commit_busy), 1);
    chk("copy_ready_low", 32'(cfg_ready), 0);
    wait_copy(n);
    chk("copy_len", 32'(n), 8);
    chk("copy_ready_back", 32'(cfg_ready), 1);
    pix(508, 316, 1'b1, v); chk("e0_topleft", 32'(v), 3);
    pix(527, 316, 1'b1, v); chk("e0_right_out", 32'(v), 0);
    pix(526, 385, 1'b1, v); chk("e0_botright", 32'(v), 3);
    pix(508, 386, 1'b1, v); chk("e0_below", 32'(v), 0);
    pix(507, 320, 1'b1, v); chk("e0_left_out", 32'(v), 0);
    pix(510, 320, 1'b0, v); chk("e0_no_draw", 32'(v), 0);

    // Animate without pending writes stays idle
    pulse_anim();
    chk("anim_clean_busy", 32'(commit_busy), 0);

    // Overlap: entry 0 outranks entry 1
    wr_rect(1, 494, 520, 300, 400, 5, 0, 1);
    pulse_anim();
    wait_copy(n);
    chk("copy2_len", 32'(n), 8);
    pix(510, 320, 1'b1, v); chk("ovl_e0_wins", 32'(v), 3);
    pix(495, 320, 1'b1, v); chk("ovl_e1", 32'(v), 5);
    pix(494, 300, 1'b1, v); chk("ovl_e1_corner", 32'(v), 5);

    // Inverted x range never hits
    wr_rect(2, 600, 590, 0, 1000, 7, 7, 1);
    pulse_anim();
    wait_copy(n);
    pix(595, 320, 1'b1, v); chk("inv_mid", 32'(v), 0);
    pix(600, 320, 1'b1, v); chk("inv_x0", 32'(v), 0);

    // Blinking every 2 frames, then disabled
    blink_frames = 8'd2;
    pix(510, 320, 1'b1, v); chk("blink_f0", 32'(v), 3);
    for (int k = 0; k < 4; k++) begin
      pulse_anim();
      pix(510, 320, 1'b1, v);
      chk("blink_seq", 32'(v), 32'(exp_blink[k]));
    end
    pulse_anim();
    pix(510, 320, 1'b1, v); chk("blink_f5", 32'(v), 3);
    pulse_anim();
    pix(510, 320, 1'b1, v); chk("blink_f6", 32'(v), 4);
    blink_frames = 8'd0;
    pix(510, 320, 1'b1, v); chk("blink_off", 32'(v), 3);
    pulse_anim();
    pix(510, 320, 1'b1, v); chk("blink_off_anim", 32'(v), 3);

    // Write accepted in the same cycle as animate joins the copy
    cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_field = 3'd4; cfg_data = 12'd6;
    animate = 1'b1;
    tick();
    cfg_valid = 1'b0; animate = 1'b0;
    chk("same_cyc_busy", 32'(commit_busy), 1);
    wait_copy(n);
    chk("same_cyc_len", 32'(n), 8);
    pix(510, 320, 1'b1, v); chk("same_cyc_val", 32'(v), 6);

    // Config held off during COPY, lands in shadow only afterwards
    cfg_wr(1, 4, 10);
    pulse_anim();
    cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_field = 3'd4; cfg_data = 12'd12;
    chk("copy_blocks_ready", 32'(cfg_ready), 0);
    n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("ready_returns", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    pix(510, 320, 1'b1, v); chk("held_not_active", 32'(v), 6);
    pix(495, 320, 1'b1, v); chk("e1_updated", 32'(v), 10);
    pulse_anim();
    wait_copy(n);
    pix(510, 320, 1'b1, v); chk("held_committed", 32'(v), 12);

    // Reset in the middle of a copy
    cfg_wr(3, 4, 1);
    pulse_anim();
    tick(); tick(); tick();
    chk("pre_rst_busy", 32'(commit_busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(commit_busy), 0);
    chk("rst_mid_pix", 32'(pix_idx), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_ready", 32'(cfg_ready), 1);
    pix(510, 320, 1'b1, v); chk("rst_mid_e0", 32'(v), 0);
    pix(495, 320, 1'b1, v); chk("rst_mid_e1", 32'(v), 0);
    pulse_anim();
    chk("rst_mid_no_dirty", 32'(commit_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
